// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: CPU-side access controller for the UART register bank (request -> strobe -> response)
module uart_reg_ctrl #(
    parameter int NUM_REGS   = 4,
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_we_i,
    input  logic [ADDR_WIDTH-1:0]         req_addr_i,
    input  logic [REG_WIDTH-1:0]          req_wdata_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [REG_WIDTH-1:0]          rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic [NUM_REGS-1:0]           reg_wr_en_o,
    output logic [NUM_REGS-1:0]           reg_rd_en_o,
    output logic [REG_WIDTH-1:0]          reg_wdata_o,
    input  logic [NUM_REGS*REG_WIDTH-1:0] reg_rdata_i
);
    localparam int IW = ADDR_WIDTH - 2;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic [IW-1:0] idx;
    logic we;
    logic hit;
    logic [REG_WIDTH-1:0] regs [2**IW];
    logic [IW-1:0] req_idx;
    logic req_hit;
    logic [NUM_REGS-1:0] req_sel;
    assign req_idx = req_addr_i[ADDR_WIDTH-1:2];
    assign req_hit = (req_addr_i[1:0] == 2'b00) && (int'(req_idx) < NUM_REGS);
    assign req_sel = req_hit ? NUM_REGS'(1) << req_idx : '0;
    // Read mux padded to a power of two so the captured index always selects in range
    for (genvar i = 0; i < 2**IW; i++) begin : g_rd
        if (i < NUM_REGS) begin : g_on
            assign regs[i] = reg_rdata_i[i*REG_WIDTH +: REG_WIDTH];
        end else begin : g_off
            assign regs[i] = '0;
        end
    end
    // Strobes are registered at acceptance so they are high exactly during ACCESS
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            reg_wr_en_o <= '0;
            reg_rd_en_o <= '0;
            reg_wdata_o <= '0;
            idx         <= '0;
            we          <= 1'b0;
            hit         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    state       <= ACCESS;
                    req_ready_o <= 1'b0;
                    we          <= req_we_i;
                    idx         <= req_idx;
                    hit         <= req_hit;
                    reg_wdata_o <= req_wdata_i;
                    reg_wr_en_o <= req_we_i ? req_sel : '0;
                    reg_rd_en_o <= req_we_i ? '0 : req_sel;
                end
                ACCESS: begin
                    state       <= RESP;
                    reg_wr_en_o <= '0;
                    reg_rd_en_o <= '0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= !hit;
                    rsp_rdata_o <= (hit && !we) ? regs[idx] : '0;
                end
                RESP: if (rsp_ready_i) begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    req_ready_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
